eeprom_test_ctrl: RTL

Sequencer that sits directly upstream of the I2C EEPROM byte driver: on `start` it writes a deterministic pattern to a block of EEPROM addresses, one byte per driver transaction. It waits out the EEPROM internal write cycle after each byte, then reads every byte back and compares it against the pattern. It owns the driver's command inputs (`exec`, `we`, `addr_hl`, `word_addr`, `wdata`), consumes `rdata`/`done`, and reports pass/fail to board-level status logic (LEDs).

---
 rtl/eeprom_pkg.sv | 34 +++
 rtl/eeprom_test_ctrl_cycle_delay.sv | 41 ++++
 rtl/eeprom_test_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/eeprom_pkg.sv
// ----------------------------------------------------------------------------
// eeprom_pkg
// Shared definitions for the EEPROM write/read-back test sequencer:
//   - state_t      : FSM state encoding
//   - twr_cycles   : write-cycle wait in clock cycles from clock rate and us
//   - pattern_byte : test pattern byte for a given word address and seed
// ----------------------------------------------------------------------------
package eeprom_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_REQ  = 4'd1,
        ST_WR_EXEC = 4'd2,
        ST_WR_WAIT = 4'd3,
        ST_TWR     = 4'd4,
        ST_RD_REQ  = 4'd5,
        ST_RD_EXEC = 4'd6,
        ST_RD_WAIT = 4'd7,
        ST_CHECK   = 4'd8,
        ST_DONE    = 4'd9
    } state_t;

    function automatic int twr_cycles(input int clk_freq, input int twr_us);
        return (clk_freq / 1_000_000) * twr_us;
    endfunction

    // Pattern depends only on the low address byte so it is cheap to regenerate
    // at compare time.
    function automatic logic [7:0] pattern_byte(input logic [15:0] addr,
                                                input logic [7:0]  seed);
        return addr[7:0] + seed;
    endfunction

endpackage

// File: rtl/eeprom_test_ctrl_cycle_delay.sv
// ----------------------------------------------------------------------------
// cycle_delay
// Load/expire down-counter. A load pulse starts a wait; 'expired' is high in
// the COUNT-th cycle after the load edge (and whenever the counter is idle),
// so a state that exits on 'expired' lasts exactly COUNT cycles.
// Ports:
//   clk     in  1 : clock
//   rst     in  1 : asynchronous active-high reset
//   load    in  1 : restart the wait
//   expired out 1 : wait finished / idle
// ----------------------------------------------------------------------------
module cycle_delay #(
    parameter int COUNT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int W        = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int LOAD_VAL = (COUNT > 0) ? COUNT - 1 : 0;

    logic [W-1:0] cnt_r;

    // Down-counter: reload on request, otherwise count down to zero and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= W'(0);
        end else if (load) begin
            cnt_r <= W'(LOAD_VAL);
        end else if (cnt_r != W'(0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == W'(0));

endmodule

// File: rtl/eeprom_test_ctrl.sv
// ----------------------------------------------------------------------------
// eeprom_test_ctrl
// Writes a deterministic pattern to NUM_BYTES EEPROM addresses through the I2C
// byte driver, waits out the EEPROM write cycle after each byte, reads every
// byte back and compares it against the pattern. Reports sticky pass/fail.
// Optional feature macro: EEPROM_ERR_CNT_EN
//   defined   : every byte is read back, err_cnt counts mismatches (sat. 255)
//   undefined : first mismatch ends the pass, err_cnt tied to 0
// Ports:
//   clk, rst (async, active-high)
//   start          in  1  : start a pass (ignored while busy)
//   drv_exec       out 1  : one-cycle command pulse to the driver
//   drv_we         out 1  : 1 = write, 0 = read
//   drv_addr_hl    out 1  : constant ADDR_HL
//   drv_word_addr  out 16 : EEPROM word address
//   drv_wdata      out 8  : write byte
//   drv_rdata      in  8  : read byte, valid at drv_done rising edge
//   drv_done       in  1  : driver completion level
//   busy, finish, pass, fail, err_cnt[7:0] : status
// ----------------------------------------------------------------------------
module eeprom_test_ctrl
    import eeprom_pkg::*;
#(
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          TWR_US    = 5,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          NUM_BYTES = 16,
    parameter logic [7:0]  SEED      = 8'h5A,
    parameter logic        ADDR_HL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        drv_exec,
    output logic        drv_we,
    output logic        drv_addr_hl,
    output logic [15:0] drv_word_addr,
    output logic [7:0]  drv_wdata,
    input  logic [7:0]  drv_rdata,
    input  logic        drv_done,
    output logic        busy,
    output logic        finish,
    output logic        pass,
    output logic        fail,
    output logic [7:0]  err_cnt
);

    localparam int         TWR_CYCLES = twr_cycles(CLK_FREQ, TWR_US);
    localparam logic [8:0] LAST_IDX   = 9'(NUM_BYTES - 1);

    state_t      state_r, state_nxt;
    logic [8:0]  idx_r, idx_nxt;
    logic [15:0] addr_nxt_s;
    logic        done_d_r;
    logic        cmpl_s;
    logic        twr_load_s;
    logic        twr_expired_s;
    logic        clear_s;
    logic        mismatch_s;
    logic        mis_total_s;
    logic        stop_s;
    logic        mis_seen_r;
    logic [7:0]  rdata_r;

    logic        exec_r, we_r, busy_r, finish_r, pass_r, fail_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;

    cycle_delay #(.COUNT(TWR_CYCLES)) u_twr (
        .clk     (clk),
        .rst     (rst),
        .load    (twr_load_s),
        .expired (twr_expired_s)
    );

    // Next-state, index and control decode
    always_comb begin
        state_nxt   = state_r;
        idx_nxt     = idx_r;
        twr_load_s  = 1'b0;
        clear_s     = 1'b0;
        // Only a rising edge counts: a level left over from the previous
        // transaction must not complete the current one.
        cmpl_s      = drv_done & ~done_d_r;
        mismatch_s  = (state_r == ST_CHECK) &&
                      (rdata_r != pattern_byte(BASE_ADDR + {7'd0, idx_r}, SEED));
        mis_total_s = mis_seen_r | mismatch_s;
`ifdef EEPROM_ERR_CNT_EN
        stop_s      = 1'b0;
`else
        stop_s      = mismatch_s;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clear_s   = 1'b1;
                    idx_nxt   = 9'd0;
                    state_nxt = ST_WR_REQ;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_REQ:  state_nxt = ST_WR_EXEC;
            ST_WR_EXEC: state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (cmpl_s) begin
                    twr_load_s = 1'b1;
                    state_nxt  = ST_TWR;
                end else begin
                    state_nxt  = ST_WR_WAIT;
                end
            end
            ST_TWR: begin
                if (!twr_expired_s) begin
                    state_nxt = ST_TWR;
                end else if (idx_r == LAST_IDX) begin
                    idx_nxt   = 9'd0;
                    state_nxt = ST_RD_REQ;
                end else begin
                    idx_nxt   = idx_r + 9'd1;
                    state_nxt = ST_WR_REQ;
                end
            end
            ST_RD_REQ:  state_nxt = ST_RD_EXEC;
            ST_RD_EXEC: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (cmpl_s) begin
                    state_nxt = ST_CHECK;
                end else begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_CHECK: begin
                if ((idx_r == LAST_IDX) || stop_s) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt   = idx_r + 9'd1;
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        addr_nxt_s = BASE_ADDR + {7'd0, idx_nxt};
    end

    // State, index and registered driver/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 9'd0;
            done_d_r   <= 1'b0;
            rdata_r    <= 8'h00;
            mis_seen_r <= 1'b0;
            exec_r     <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 16'h0000;
            wdata_r    <= 8'h00;
            busy_r     <= 1'b0;
            finish_r   <= 1'b0;
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            idx_r    <= idx_nxt;
            done_d_r <= drv_done;
            exec_r   <= (state_nxt == ST_WR_EXEC) || (state_nxt == ST_RD_EXEC);
            busy_r   <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            finish_r <= (state_nxt == ST_DONE);
            // Command fields load on entry to a REQ state, one cycle ahead of exec
            if (state_nxt == ST_WR_REQ) begin
                addr_r  <= addr_nxt_s;
                we_r    <= 1'b1;
                wdata_r <= pattern_byte(addr_nxt_s, SEED);
            end else if (state_nxt == ST_RD_REQ) begin
                addr_r  <= addr_nxt_s;
                we_r    <= 1'b0;
            end else begin
                addr_r  <= addr_r;
            end
            if ((state_r == ST_RD_WAIT) && cmpl_s) begin
                rdata_r <= drv_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
            // Result flags land together with the finish pulse
            if (clear_s) begin
                mis_seen_r <= 1'b0;
                pass_r     <= 1'b0;
                fail_r     <= 1'b0;
            end else if (state_nxt == ST_DONE) begin
                mis_seen_r <= mis_total_s;
                pass_r     <= ~mis_total_s;
                fail_r     <= mis_total_s;
            end else begin
                mis_seen_r <= mis_total_s;
            end
        end
    end

`ifdef EEPROM_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Mismatch counter, saturating at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if (clear_s) begin
            err_cnt_r <= 8'h00;
        end else if (mismatch_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'h00;
`endif

    assign drv_exec      = exec_r;
    assign drv_we        = we_r;
    assign drv_addr_hl   = ADDR_HL;
    assign drv_word_addr = addr_r;
    assign drv_wdata     = wdata_r;
    assign busy          = busy_r;
    assign finish        = finish_r;
    assign pass          = pass_r;
    assign fail          = fail_r;

endmodule
